// File: rtl/serial_adder_controller_if.sv
// Host-side handshake and operand/result bus for serial_adder_controller.
// SERIAL_ADDER_SUBTRACT_EN adds the sub request bit.
interface serial_adder_controller_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
`ifdef SERIAL_ADDER_SUBTRACT_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;

`ifdef SERIAL_ADDER_SUBTRACT_EN
    modport master (output start, a, b, carry_in, sub, input busy, done, sum, carry_out);
    modport slave  (input start, a, b, carry_in, sub, output busy, done, sum, carry_out);
`else
    modport master (output start, a, b, carry_in, input busy, done, sum, carry_out);
    modport slave  (input start, a, b, carry_in, output busy, done, sum, carry_out);
`endif
endinterface

// File: rtl/serial_adder_controller.sv
// Bit-serial adder: one full-adder cell sequenced LSB first over WIDTH cycles.
// Optional SERIAL_ADDER_SUBTRACT_EN enables a-b via inverted B and forced carry-in.
module serial_adder_controller #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                      clock,
    input  logic                      reset_n,
    serial_adder_controller_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    count_q, count_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;

    logic [WIDTH-1:0] b_load_c;
    logic             c_load_c;
    logic             fa_sum_c;
    logic             fa_cout_c;

    // Operand B and initial carry as loaded on an accepted start
`ifdef SERIAL_ADDER_SUBTRACT_EN
    assign b_load_c = bus.sub ? ~bus.b : bus.b;
    assign c_load_c = bus.sub ? 1'b1 : bus.carry_in;
`else
    assign b_load_c = bus.b;
    assign c_load_c = bus.carry_in;
`endif

    // The single full-adder cell
    assign fa_sum_c  = sa_q[0] ^ sb_q[0] ^ carry_q;
    assign fa_cout_c = (sa_q[0] & sb_q[0]) | (carry_q & (sa_q[0] ^ sb_q[0]));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            count_q <= '0;
            carry_q <= 1'b0;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            count_q <= count_d;
            carry_q <= carry_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sum_d   = sum_q;
        cout_d  = cout_q;
        count_d = count_q;
        carry_d = carry_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sa_d    = bus.a;
                    sb_d    = b_load_c;
                    carry_d = c_load_c;
                    count_d = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                sa_d    = sa_q >> 1;
                sb_d    = sb_q >> 1;
                carry_d = fa_cout_c;
                // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts
                res_d   = WIDTH'({fa_sum_c, res_q} >> 1);
                if (count_q == LAST) begin
                    sum_d   = res_d;
                    cout_d  = fa_cout_c;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.sum       = sum_q;
    assign bus.carry_out = cout_q;
endmodule

// File: tb/tb_serial_adder_controller.sv
// Directed self-checking bench for serial_adder_controller (WIDTH=8).
// Covers SERIAL_ADDER_SUBTRACT_EN vectors when that macro is defined.
module tb_serial_adder_controller;
    localparam int unsigned WIDTH = 8;

    logic clock = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    int   lat;
    int   nbusy;
    int   ndone;

    serial_adder_controller_if #(.WIDTH(WIDTH)) bus ();

    serial_adder_controller #(.WIDTH(WIDTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present operands with start for one edge, then scramble the inputs
    task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic ci);
        bus.a        = av;
        bus.b        = bv;
        bus.carry_in = ci;
        bus.start    = 1'b1;
        step();
        bus.start    = 1'b0;
        bus.a        = 8'($urandom);
        bus.b        = 8'($urandom);
        bus.carry_in = 1'($urandom);
    endtask

    task automatic wait_done(output int l, output int nb);
        l  = 0;
        nb = 0;
        while (bus.done !== 1'b1 && l < 40) begin
            if (bus.busy === 1'b1) nb++;
            step();
            l++;
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        bus.start    = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.carry_in = 1'b0;
`ifdef SERIAL_ADDER_SUBTRACT_EN
        bus.sub      = 1'b0;
`endif
        step();
        step();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_sum",  32'(bus.sum), 32'h00);
        check("rst_cout", 32'(bus.carry_out), 32'd0);
        reset_n = 1'b1;

        // 1) zero + zero
        start_op(8'h00, 8'h00, 1'b0);
        check("t1_busy_after_start", 32'(bus.busy), 32'd1);
        check("t1_done_after_start", 32'(bus.done), 32'd0);
        wait_done(lat, nbusy);
        check("t1_latency", 32'(lat), 32'd8);
        check("t1_sum",  32'(bus.sum), 32'h00);
        check("t1_cout", 32'(bus.carry_out), 32'd0);

        // 2) overflow into carry_out, busy/done widths
        start_op(8'hFF, 8'h01, 1'b0);
        wait_done(lat, nbusy);
        check("t2_done",   32'(bus.done), 32'd1);
        check("t2_latency", 32'(lat), 32'd8);
        check("t2_busy_cycles", 32'(nbusy), 32'd8);
        check("t2_sum",  32'(bus.sum), 32'h00);
        check("t2_cout", 32'(bus.carry_out), 32'd1);
        step();
        check("t2_done_pulse_width", 32'(bus.done), 32'd0);
        check("t2_busy_after", 32'(bus.busy), 32'd0);
        check("t2_sum_held", 32'(bus.sum), 32'h00);

        // 3) carry_in used; back-to-back start in the done cycle
        start_op(8'h5A, 8'h3C, 1'b1);
        wait_done(lat, nbusy);
        check("t3_sum",  32'(bus.sum), 32'h97);
        check("t3_cout", 32'(bus.carry_out), 32'd0);
        start_op(8'h12, 8'h34, 1'b0);
        check("t3_b2b_accepted", 32'(bus.busy), 32'd1);
        check("t3_b2b_sum_held", 32'(bus.sum), 32'h97);
        wait_done(lat, nbusy);
        check("t3_b2b_latency", 32'(lat + 1), 32'd9);
        check("t3_b2b_sum",  32'(bus.sum), 32'h46);
        check("t3_b2b_cout", 32'(bus.carry_out), 32'd0);

        // 4) start while busy is ignored
        start_op(8'h0F, 8'h01, 1'b0);
        step();
        step();
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("t4_busy_midrun", 32'(bus.busy), 32'd1);
        check("t4_sum_held_midrun", 32'(bus.sum), 32'h46);
        wait_done(lat, nbusy);
        check("t4_latency_rest", 32'(lat), 32'd5);
        check("t4_sum",  32'(bus.sum), 32'h10);
        check("t4_cout", 32'(bus.carry_out), 32'd0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
        end
        check("t4_no_queued_op", 32'(ndone), 32'd0);

        // 5) reset mid-run
        start_op(8'h33, 8'h44, 1'b0);
        for (int i = 0; i < 4; i++) step();
        reset_n = 1'b0;
        #1;
        check("t5_rst_busy", 32'(bus.busy), 32'd0);
        check("t5_rst_done", 32'(bus.done), 32'd0);
        check("t5_rst_sum",  32'(bus.sum), 32'h00);
        check("t5_rst_cout", 32'(bus.carry_out), 32'd0);
        step();
        reset_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.done === 1'b1) ndone++;
        end
        check("t5_no_done_after_reset", 32'(ndone), 32'd0);
        start_op(8'h80, 8'h80, 1'b1);
        wait_done(lat, nbusy);
        check("t5_fresh_latency", 32'(lat), 32'd8);
        check("t5_fresh_sum",  32'(bus.sum), 32'h01);
        check("t5_fresh_cout", 32'(bus.carry_out), 32'd1);

        // Carry ripples through every bit
        start_op(8'hAA, 8'h55, 1'b1);
        wait_done(lat, nbusy);
        check("ripple_sum",  32'(bus.sum), 32'h00);
        check("ripple_cout", 32'(bus.carry_out), 32'd1);

`ifdef SERIAL_ADDER_SUBTRACT_EN
        // 6) subtraction
        bus.sub = 1'b1;
        start_op(8'h10, 8'h01, 1'b0);
        wait_done(lat, nbusy);
        check("t6_sub_sum",  32'(bus.sum), 32'h0F);
        check("t6_sub_cout", 32'(bus.carry_out), 32'd1);
        start_op(8'h01, 8'h02, 1'b1);
        wait_done(lat, nbusy);
        check("t6_borrow_sum",  32'(bus.sum), 32'hFF);
        check("t6_borrow_cout", 32'(bus.carry_out), 32'd0);
        bus.sub = 1'b0;
        start_op(8'h01, 8'h02, 1'b0);
        wait_done(lat, nbusy);
        check("t6_add_sum",  32'(bus.sum), 32'h03);
        check("t6_add_cout", 32'(bus.carry_out), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
